// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit:
//   - FSM state encoding
//   - opcode field position and default HALT opcode
//   - word-alignment check value for NPC[1:0]
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } ifu_state_e;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

  localparam logic [1:0] WORD_ALIGN = 2'b00;

  // Instruction opcode field
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Architectural PC register with its PC+4 incrementer.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset (PC <= RESET_PC)
//   load_i    - load d_i into PC on the next rising edge
//   d_i       - new PC value
//   pc_o      - current PC
//   pc_plus_o - PC + 4, modulo 2^32
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign pc_o      = pc_q;
  assign pc_plus_o = pc_q + 32'd4;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side sequencer: holds the PC, fetches one word over a req/ack
// handshake, presents IR/PC/PC_plus to decode/execute, then waits for a
// committed NPC before fetching again. Stops on HALT opcode or misaligned NPC.
// Ports:
//   clk, rst              - clock (rising edge), async active-high reset
//   start                 - leave IDLE and begin fetching (IDLE only)
//   IMEM_req/IMEM_addr    - fetch request and address (address = PC)
//   IMEM_ack/IMEM_data    - fetch completion and instruction word
//   IR, IR_valid          - captured instruction and its valid flag
//   PC, PC_plus           - address of IR and PC+4
//   NPC, NPC_valid        - next PC and its one-cycle commit strobe
//   halted, fault         - terminal status flags
//   instr_count           - saturating committed-instruction counter
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        IMEM_req,
  output logic [31:0] IMEM_addr,
  input  logic        IMEM_ack,
  input  logic [31:0] IMEM_data,
  output logic [31:0] IR,
  output logic        IR_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus,
  input  logic [31:0] NPC,
  input  logic        NPC_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  ifu_state_e  state_q;
  logic [31:0] ir_q;
  logic [31:0] count_q;
  logic        npc_aligned;
  logic        pc_load;

  assign npc_aligned = (NPC[1:0] == WORD_ALIGN);
  assign pc_load     = (state_q == EXEC) && NPC_valid && npc_aligned;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .d_i       (NPC),
    .pc_o      (PC),
    .pc_plus_o (PC_plus)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= REQ;
          end
        end
        REQ: begin
          if (IMEM_ack) begin
            ir_q <= IMEM_data;
            if (opcode_of(IMEM_data) == HALT_OPCODE) begin
              state_q <= HALT;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          if (NPC_valid) begin
            if (!npc_aligned) begin
              state_q <= FAULT;
            end else begin
              if (count_q != '1) begin
                count_q <= count_q + 32'd1;
              end
              state_q <= REQ;
            end
          end
        end
        default: begin
          // HALT and FAULT are terminal until reset
          state_q <= state_q;
        end
      endcase
    end
  end

  // Status outputs decode the registered state only, so an async reset
  // drops IMEM_req immediately and no input reaches an output directly.
  assign IMEM_req    = (state_q == REQ);
  assign IMEM_addr   = PC;
  assign IR          = ir_q;
  assign IR_valid    = (state_q == EXEC);
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default RESET_PC
  logic        rst, start, ack, nv;
  logic [31:0] data, npc;
  logic        req, ir_valid, halted, fault;
  logic [31:0] addr, ir, pc, pc_plus, cnt;

  // DUT B: RESET_PC at top of address space
  logic        b_rst, b_start, b_ack, b_nv;
  logic [31:0] b_data, b_npc;
  logic        b_req, b_ir_valid, b_halted, b_fault;
  logic [31:0] b_addr, b_ir, b_pc, b_pc_plus, b_cnt;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  instr_fetch_unit dut_a (
    .clk (clk), .rst (rst), .start (start),
    .IMEM_req (req), .IMEM_addr (addr), .IMEM_ack (ack), .IMEM_data (data),
    .IR (ir), .IR_valid (ir_valid), .PC (pc), .PC_plus (pc_plus),
    .NPC (npc), .NPC_valid (nv), .halted (halted), .fault (fault),
    .instr_count (cnt)
  );

  instr_fetch_unit #(.RESET_PC (32'hFFFF_FFFC)) dut_b (
    .clk (clk), .rst (b_rst), .start (b_start),
    .IMEM_req (b_req), .IMEM_addr (b_addr), .IMEM_ack (b_ack), .IMEM_data (b_data),
    .IR (b_ir), .IR_valid (b_ir_valid), .PC (b_pc), .PC_plus (b_pc_plus),
    .NPC (b_npc), .NPC_valid (b_nv), .halted (b_halted), .fault (b_fault),
    .instr_count (b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; nv = 1'b0; data = '0; npc = '0;
    b_rst = 1'b1; b_start = 1'b0; b_ack = 1'b0; b_nv = 1'b0; b_data = '0; b_npc = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus", pc_plus, 32'h4);
    chk("rst_ir", ir, 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_flags", {29'd0, ir_valid, halted, fault}, 32'd0);

    // First fetch, ack on first REQ cycle
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("f1_req", {31'd0, req}, 32'd1);
    chk("f1_addr", addr, 32'h0);
    chk("f1_irv_low", {31'd0, ir_valid}, 32'd0);
    start = 1'b0; ack = 1'b1; data = 32'h0400_0001;
    @(negedge clk);
    chk("f1_ir", ir, 32'h0400_0001);
    chk("f1_irv", {31'd0, ir_valid}, 32'd1);
    chk("f1_pc_plus", pc_plus, 32'h4);
    chk("f1_req_low", {31'd0, req}, 32'd0);

    // Commit NPC=0x10
    ack = 1'b0; data = 32'hDEAD_BEEF; npc = 32'h10; nv = 1'b1;
    @(negedge clk);
    chk("c1_addr", addr, 32'h10);
    chk("c1_cnt", cnt, 32'd1);
    chk("c1_irv", {31'd0, ir_valid}, 32'd0);
    chk("c1_req", {31'd0, req}, 32'd1);

    // Five-cycle ack stall; NPC_valid and junk data must be ignored
    npc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, req}, 32'd1);
      chk("stall_addr", addr, 32'h10);
      chk("stall_ir", ir, 32'h0400_0001);
    end
    nv = 1'b0; ack = 1'b1; data = 32'h0800_0002;
    @(negedge clk);
    chk("f2_ir", ir, 32'h0800_0002);
    chk("f2_pc", pc, 32'h10);
    chk("f2_irv", {31'd0, ir_valid}, 32'd1);

    // Fall-through NPC = PC_plus
    ack = 1'b0; npc = 32'h14; nv = 1'b1;
    @(negedge clk);
    chk("ft_addr", addr, 32'h14);
    chk("ft_cnt", cnt, 32'd2);
    nv = 1'b0; ack = 1'b1; data = 32'h0C00_0003;
    @(negedge clk);
    chk("ft_ir", ir, 32'h0C00_0003);

    // Self-loop NPC = PC
    ack = 1'b0; npc = 32'h14; nv = 1'b1;
    @(negedge clk);
    chk("sl_addr", addr, 32'h14);
    chk("sl_cnt", cnt, 32'd3);
    nv = 1'b0; ack = 1'b1; data = 32'h1000_0004;
    @(negedge clk);
    chk("sl_pc", pc, 32'h14);
    chk("sl_irv", {31'd0, ir_valid}, 32'd1);

    // Misaligned NPC -> FAULT
    ack = 1'b0; npc = 32'h16; nv = 1'b1;
    @(negedge clk);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_pc", pc, 32'h14);
    chk("mis_cnt", cnt, 32'd3);
    chk("mis_req", {31'd0, req}, 32'd0);
    chk("mis_irv", {31'd0, ir_valid}, 32'd0);
    start = 1'b1; ack = 1'b1; npc = 32'h20;
    repeat (2) @(negedge clk);
    chk("fault_hold", {30'd0, fault, req}, 32'd2);
    chk("fault_pc", pc, 32'h14);
    chk("fault_cnt", cnt, 32'd3);
    start = 1'b0; ack = 1'b0; nv = 1'b0;

    // Reset clears fault, then async reset mid-REQ
    rst = 1'b1;
    #1;
    chk("rst2_fault", {31'd0, fault}, 32'd0);
    chk("rst2_cnt", cnt, 32'd0);
    chk("rst2_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b1; data = 32'h0400_0000;
    @(negedge clk);
    ack = 1'b0; npc = 32'h20; nv = 1'b1;
    @(negedge clk);
    nv = 1'b0;
    chk("mr_req", {31'd0, req}, 32'd1);
    chk("mr_addr", addr, 32'h20);
    rst = 1'b1;
    #1;
    chk("mr_req_drop", {31'd0, req}, 32'd0);
    chk("mr_pc", pc, 32'h0);

    // HALT opcode
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b1; data = 32'hFC00_0000;
    @(negedge clk);
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_irv", {31'd0, ir_valid}, 32'd0);
    chk("h_ir", ir, 32'hFC00_0000);
    chk("h_cnt", cnt, 32'd0);
    chk("h_req", {31'd0, req}, 32'd0);
    ack = 1'b0; start = 1'b1; nv = 1'b1; npc = 32'h40;
    repeat (3) @(negedge clk);
    chk("h_hold", {29'd0, halted, req, ir_valid}, 32'd4);
    chk("h_pc", pc, 32'h0);
    nv = 1'b0;

    // Simultaneous rst and start: rst wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rs_req", {30'd0, req, halted}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rs_idle", {31'd0, req}, 32'd0);

    // DUT B: PC wrap at top of address space
    chk("b_rst_pc", b_pc, 32'hFFFF_FFFC);
    chk("b_rst_pc_plus", b_pc_plus, 32'h0);
    b_rst = 1'b0; b_start = 1'b1;
    @(negedge clk);
    chk("b_req", {31'd0, b_req}, 32'd1);
    chk("b_addr", b_addr, 32'hFFFF_FFFC);
    b_start = 1'b0; b_ack = 1'b1; b_data = 32'h0400_0000;
    @(negedge clk);
    chk("b_irv", {31'd0, b_ir_valid}, 32'd1);
    b_ack = 1'b0; b_npc = 32'h0; b_nv = 1'b1;
    @(negedge clk);
    b_nv = 1'b0;
    chk("b_wrap_addr", b_addr, 32'h0);
    chk("b_wrap_cnt", b_cnt, 32'd1);
    chk("b_wrap_pc_plus", b_pc_plus, 32'h4);
    b_ack = 1'b1; b_data = 32'h0800_0000;
    @(negedge clk);
    b_ack = 1'b0;
    chk("b_ir2", b_ir, 32'h0800_0000);
    chk("b_pc2", b_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side sequencer that feeds the branch/next-PC logic and consumes its result. Holds the architectural PC, issues word fetches to instruction memory over a req/ack handshake, and presents IR, PC and PC_plus (PC+4) to decode/execute. Waits for a committed NPC from the execute stage, then loads it and fetches again. Stops on a HALT opcode or a misaligned NPC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_OPCODE, 6'b111111, value of IR[31:26] that halts the core.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin execution from PC; sampled only in IDLE
IMEM_req  out  1  fetch request; held until IMEM_ack
IMEM_addr  out  32  fetch address; equals PC, stable while IMEM_req=1
IMEM_ack  in  1  memory has IMEM_data valid this cycle
IMEM_data  in  32  fetched instruction word
IR  out  32  captured instruction
IR_valid  out  1  IR/PC/PC_plus valid for decode/execute
PC  out  32  address of the instruction in IR
PC_plus  out  32  PC+4, modulo 2^32
NPC  in  32  next PC from branch control
NPC_valid  in  1  one-cycle commit strobe for NPC
halted  out  1  core stopped on HALT_OPCODE
fault  out  1  core stopped on misaligned NPC
instr_count  out  32  committed-instruction counter

Behaviour:
- Reset (async, any state): state=IDLE, PC=RESET_PC, IR=0, instr_count=0, IMEM_req=0, IR_valid=0, halted=0, fault=0.
- All outputs are registered or decoded from state only. No combinational path from input to output.
- States:
  - IDLE: start=1 -> REQ.
  - REQ: IMEM_req=1, IMEM_addr=PC. On an edge with IMEM_ack=1, IR<=IMEM_data. Then:
    - IMEM_data[31:26]==HALT_OPCODE -> HALT.
    - otherwise -> EXEC.
  - EXEC: IR_valid=1. On an edge with NPC_valid=1:
    - NPC[1:0]!=0 -> FAULT; PC unchanged, instr_count unchanged.
    - otherwise PC<=NPC, instr_count+=1, -> REQ.
  - HALT: halted=1; terminal until rst.
  - FAULT: fault=1; terminal until rst.
- Timing:
  - Minimum fetch latency is 1 cycle: ack may arrive on the first REQ cycle.
  - Minimum loop is 2 cycles per instruction (REQ, EXEC).
- PC_plus = PC + 4 at all times, wrapping: PC=32'hFFFF_FFFC gives PC_plus=0.
- NPC=PC_plus (fall-through) and NPC=PC (self-loop) are both legal.
- Ignored inputs:
  - start outside IDLE.
  - IMEM_ack outside REQ.
  - NPC_valid outside EXEC.
  - IMEM_data when IMEM_ack=0.
- instr_count saturates at 32'hFFFF_FFFF.
- A HALT instruction is not counted. HALT is not presented with IR_valid.
- Reset asserted mid-REQ drops IMEM_req in the same cycle (async). The memory must tolerate an abandoned request.
- Simultaneous start and rst: rst wins.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=3'd0, REQ=3'd1, EXEC=3'd2, HALT=3'd3, FAULT=3'd4.
  - OPCODE field slice constants [31:26].
  - HALT_OPCODE default.
  - Word-alignment mask 2'b00.
- One natural sub-module, pc_register: PC register with reset value, load enable and the PC+4 adder.
- The FSM, IR capture and counter stay in instr_fetch_unit.

Test Plan:
- Reset release, start=1, ack 1 cycle after req, IMEM_data=32'h0400_0001 -> IMEM_addr=0; IR=32'h0400_0001; IR_valid=1; PC_plus=4.
- In EXEC, NPC=32'h0000_0010 with NPC_valid=1 -> next IMEM_addr=32'h10, instr_count=1, IR_valid deasserted until next ack.
- Ack delayed 5 cycles -> IMEM_req and IMEM_addr held stable for all 5 cycles; single IR capture.
- NPC=32'h0000_0016 (misaligned) -> fault=1, PC stays at old value, no further IMEM_req, instr_count unchanged.
- Fetched word 32'hFC00_0000 -> halted=1, IR_valid never asserted, later start/NPC_valid have no effect.
- RESET_PC=32'hFFFF_FFFC -> PC_plus=0; NPC=0 commits and fetch wraps to address 0. Separately, rst pulsed mid-REQ drops IMEM_req immediately and PC returns to RESET_PC.
